// File: rtl/tc_pkg.sv
// tc_pkg: shared definitions for the tc_timer block.
//   - tc_state_e : timer FSM state encoding
//   - OFF_*      : register offsets decoded from addr[3:2]
//   - MODE_*     : CTRL.MODE encodings
//   - CTRL_*     : CTRL bit positions
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IM = 3;

endpackage

// File: rtl/tc_timer.sv
// tc_timer: bus-mapped down-counting timer with interrupt.
//
// Registers (addr[3:2]): 0 CTRL {IM,MODE[1:0],EN}, 1 PRESET (r/w),
// 2 COUNT (read-only), 3 unmapped (reads 0).
//
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   addr  - byte address, only addr[3:2] decoded
//   we    - write enable
//   din   - write data
//   dout  - combinational read of the addressed register
//   irq   - CTRL.IM & pending
//
// Build option: define TC_AUTO_RELOAD_EN to enable MODE=01 auto-reload.
// Without it every MODE behaves as one-shot and CTRL[2:1] reads 00.
module tc_timer
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;

  logic        wr_ctrl, wr_preset;
  logic        en, auto_reload, pend_set;
  logic [3:0]  ctrl_wdata;
  logic        unused_addr;

  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign wr_ctrl   = we && (addr[3:2] == OFF_CTRL);
  assign wr_preset = we && (addr[3:2] == OFF_PRESET);
  assign en        = ctrl_q[CTRL_EN];

`ifdef TC_AUTO_RELOAD_EN
  assign auto_reload = (ctrl_q[2:1] == MODE_RELOAD);
  assign ctrl_wdata  = din[3:0];
`else
  // MODE bits are not stored, so they read back as 00.
  assign auto_reload = 1'b0;
  assign ctrl_wdata  = {din[CTRL_IM], MODE_ONESHOT, din[CTRL_EN]};
`endif

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    pend_set  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = en ? ST_CNT : ST_IDLE;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Terminal count; also covers PRESET=0 so it behaves as 1.
          count_d   = 32'd0;
          pending_d = 1'b1;
          pend_set  = 1'b1;
          state_d   = ST_INT;
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes come last so they override the hardware EN clear.
    if (wr_ctrl)   ctrl_d   = ctrl_wdata;
    if (wr_preset) preset_d = din;
    // A terminal-count event on the same edge is not lost to a bus clear.
    if ((wr_ctrl || wr_preset) && !pend_set) pending_d = 1'b0;

    irq_d = ctrl_d[CTRL_IM] & pending_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    dout = 32'd0;
    case (addr[3:2])
      OFF_CTRL:   dout = {28'd0, ctrl_q};
      OFF_PRESET: dout = preset_q;
      OFF_COUNT:  dout = count_q;
      default:    dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_tc_timer.sv
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int failures = 0;

  tc_timer dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    addr = {28'd0, off, 2'b00};
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    addr = {28'd0, off, 2'b00};
    din  = data;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    irq_chk("rst_irq", 1'b0);
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_preset", 2'd1, 32'd0);
    rd_chk("rst_count", 2'd2, 32'd0);
    rd_chk("unmapped", 2'd3, 32'd0);

    // Register access; COUNT writes ignored, CTRL upper bits dropped
    wr(2'd1, 32'hDEAD_BEEF);
    rd_chk("preset_rw", 2'd1, 32'hDEAD_BEEF);
    wr(2'd2, 32'h1234_5678);
    rd_chk("count_ro", 2'd2, 32'd0);
    wr(2'd0, 32'hFFFF_FFF8);
    rd_chk("ctrl_upper", 2'd0, 32'h8);
    wr(2'd0, 32'h0);

    // One-shot: PRESET=5, CTRL=0x9
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 6; i++) begin
      tick();
      irq_chk("os_pre_irq", 1'b0);
    end
    rd_chk("os_count1", 2'd2, 32'd1);
    tick();
    irq_chk("os_irq_rise", 1'b1);
    rd_chk("os_count0", 2'd2, 32'd0);
    tick();
    rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
    irq_chk("os_irq_hold1", 1'b1);
    tick();
    tick();
    irq_chk("os_irq_hold2", 1'b1);
    rd_chk("os_count_stay0", 2'd2, 32'd0);
    wr(2'd1, 32'd7);
    irq_chk("os_irq_drop", 1'b0);
    tick();
    irq_chk("os_irq_stay_low", 1'b0);

    // Mask: PRESET=2, CTRL=0x1
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      irq_chk("mask_irq", 1'b0);
    end
    rd_chk("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h9);
    irq_chk("mask_wr_clears", 1'b0);
    tick();
    irq_chk("mask_wr_clears2", 1'b0);

    // Stop mid-count: PRESET=100
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    repeat (10) tick();
    rd_chk("stop_count92", 2'd2, 32'd92);
    wr(2'd0, 32'h0);
    rd_chk("stop_count91", 2'd2, 32'd91);
    tick();
    tick();
    tick();
    rd_chk("stop_frozen", 2'd2, 32'd91);
    rd_chk("stop_ctrl", 2'd0, 32'd0);
    irq_chk("stop_irq", 1'b0);

    // PRESET write during CNT; CTRL write in INT beats the EN clear
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    rd_chk("pw_count2", 2'd2, 32'd2);
    wr(2'd1, 32'd10);
    rd_chk("pw_count1", 2'd2, 32'd1);
    tick();
    irq_chk("pw_irq", 1'b1);
    wr(2'd0, 32'h9);
    rd_chk("int_bus_wins", 2'd0, 32'h9);
    irq_chk("int_wr_clear", 1'b0);
    tick();
    tick();
    rd_chk("pw_new_preset", 2'd2, 32'd10);

    // PRESET=0 behaves as PRESET=1
    do_reset();
    wr(2'd0, 32'h9);
    tick();
    tick();
    irq_chk("p0_irq_low", 1'b0);
    rd_chk("p0_count", 2'd2, 32'd0);
    tick();
    irq_chk("p0_irq_high", 1'b1);

    // Reset mid-count, overriding a simultaneous bus write
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    rd_chk("rm_count3", 2'd2, 32'd3);
    addr  = 32'h4;
    din   = 32'h55;
    we    = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we    = 1'b0;
    rd_chk("rm_ctrl", 2'd0, 32'd0);
    rd_chk("rm_preset", 2'd1, 32'd0);
    rd_chk("rm_count", 2'd2, 32'd0);
    irq_chk("rm_irq", 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      irq_chk("rm_irq_after", 1'b0);
    end

    // MODE=01 with PRESET=3
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
`ifdef TC_AUTO_RELOAD_EN
    rd_chk("ar_ctrl", 2'd0, 32'hB);
    tick();
    tick();
    rd_chk("ar_seq3", 2'd2, 32'd3);
    tick();
    rd_chk("ar_seq2", 2'd2, 32'd2);
    tick();
    rd_chk("ar_seq1", 2'd2, 32'd1);
    irq_chk("ar_pre", 1'b0);
    tick();
    irq_chk("ar_pulse1", 1'b1);
    rd_chk("ar_seq0", 2'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      irq_chk("ar_gap", 1'b0);
    end
    tick();
    irq_chk("ar_pulse2", 1'b1);
`else
    rd_chk("nr_ctrl", 2'd0, 32'h9);
    repeat (5) tick();
    irq_chk("nr_irq", 1'b1);
    tick();
    rd_chk("nr_ctrl_en_clr", 2'd0, 32'h8);
    tick();
    tick();
    irq_chk("nr_irq_hold", 1'b1);
    rd_chk("nr_count", 2'd2, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
